// File: rtl/call_request_unit.sv
// Floor call front end: synchronizes and debounces the three call buttons,
// latches pending calls and registers the next target floor for the controller.
module call_request_unit #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       button1_pushed,
   input  logic       button2_pushed,
   input  logic       button3_pushed,
   input  logic [1:0] current_floor,
   input  logic       door_open,
   input  logic       sos_mode,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic       next_valid,
   output logic [1:0] next_floor
);

   localparam logic [7:0] LP_N = 8'(DEBOUNCE_CYCLES);

   logic [3:1]       w_raw;
   logic [3:1]       r_s1, r_s2, r_acc, r_acc_d, r_pe, r_pend;
   logic [3:1][7:0]  r_cnt;
   logic             r_dir_up;
   logic [1:0]       r_last_floor;
   logic             r_next_valid;
   logic [1:0]       r_next_floor;
   logic             w_vld;
   logic [1:0]       w_nf;

   assign w_raw = {button3_pushed, button2_pushed, button1_pushed};

   // Synchronizer, debouncer and press-edge detector per button
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_s1    <= '1;
         r_s2    <= '1;
         r_acc   <= '1;
         r_acc_d <= '1;
         r_pe    <= '0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= w_raw;
         r_s2    <= r_s1;
         r_acc_d <= r_acc;
         r_pe    <= r_acc_d & ~r_acc;
         for (int k = 1; k <= 3; k++) begin
            if (r_s2[k] == r_acc[k]) begin
               r_cnt[k] <= '0;
            end else if (r_cnt[k] + 8'd1 == LP_N) begin
               r_acc[k] <= r_s2[k];
               r_cnt[k] <= '0;
            end else begin
               r_cnt[k] <= r_cnt[k] + 8'd1;
            end
         end
      end
   end

   // Servicing a floor beats a simultaneous press at that floor
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_pend <= '0;
      end else if (sos_mode) begin
         r_pend <= '0;
      end else begin
         for (int k = 1; k <= 3; k++) begin
            if (door_open && current_floor == 2'(k))
               r_pend[k] <= 1'b0;
            else if (r_pe[k])
               r_pend[k] <= 1'b1;
         end
      end
   end

   // Direction follows valid floor changes only; 0 (unknown) is skipped
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_dir_up     <= 1'b1;
         r_last_floor <= 2'd0;
      end else if (current_floor != 2'd0) begin
         r_last_floor <= current_floor;
         if (r_last_floor != 2'd0) begin
            if (current_floor > r_last_floor)
               r_dir_up <= 1'b1;
            else if (current_floor < r_last_floor)
               r_dir_up <= 1'b0;
         end
      end
   end

   always_comb begin
      w_vld = |r_pend;
      w_nf  = 2'd0;
      case (current_floor)
         2'd2: begin
            if (r_pend[2])                 w_nf = 2'd2;
            else if (r_pend[1] && r_pend[3]) w_nf = r_dir_up ? 2'd3 : 2'd1;
            else if (r_pend[1])            w_nf = 2'd1;
            else if (r_pend[3])            w_nf = 2'd3;
         end
         2'd3: begin
            if (r_pend[3])      w_nf = 2'd3;
            else if (r_pend[2]) w_nf = 2'd2;
            else if (r_pend[1]) w_nf = 2'd1;
         end
         default: begin
            if (r_pend[1])      w_nf = 2'd1;
            else if (r_pend[2]) w_nf = 2'd2;
            else if (r_pend[3]) w_nf = 2'd3;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_next_valid <= 1'b0;
         r_next_floor <= 2'd0;
      end else begin
         r_next_valid <= w_vld;
         r_next_floor <= w_nf;
      end
   end

   assign led1       = r_pend[1];
   assign led2       = r_pend[2];
   assign led3       = r_pend[3];
   assign next_valid = r_next_valid;
   assign next_floor = r_next_floor;

endmodule

// File: tb/tb_call_request_unit.sv
// Directed bench for call_request_unit with DEBOUNCE_CYCLES = 4.
module tb_call_request_unit;

   localparam int N = 4;

   logic       clk_50 = 1'b0;
   logic       reset;
   logic [3:1] btn;
   logic [1:0] current_floor;
   logic       door_open;
   logic       sos_mode;
   logic       led1, led2, led3, next_valid;
   logic [1:0] next_floor;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   call_request_unit #(.DEBOUNCE_CYCLES(N)) dut (
      .clk_50         (clk_50),
      .reset          (reset),
      .button1_pushed (btn[1]),
      .button2_pushed (btn[2]),
      .button3_pushed (btn[3]),
      .current_floor  (current_floor),
      .door_open      (door_open),
      .sos_mode       (sos_mode),
      .led1           (led1),
      .led2           (led2),
      .led3           (led3),
      .next_valid     (next_valid),
      .next_floor     (next_floor)
   );

   always #5 clk_50 = ~clk_50;

   // Advance one edge and settle; inputs change only here, away from the edge
   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic press(input int k, input int len);
      btn[k] = 1'b0;
      repeat (len) tick();
      btn[k] = 1'b1;
      repeat (N + 6) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; btn = 3'b111; current_floor = 2'd1;
      door_open = 1'b0; sos_mode = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      tot_cnt++;
      if ({led3, led2, led1, next_valid, next_floor} !== 6'b0)
         $display("FAIL reset_outputs got %b want 000000", {led3, led2, led1, next_valid, next_floor});
      else pass_cnt++;
   endtask

   task automatic test_press_latency();
      int pe_cnt = 0;
      btn[3] = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (dut.r_pe[3]) pe_cnt++;
         if (i == 7) begin
            tot_cnt++;
            if (led3 !== 1'b0) $display("FAIL led3_early got %b want 0", led3);
            else pass_cnt++;
         end
         if (i == 8) begin
            tot_cnt++;
            if (led3 !== 1'b1 || next_valid !== 1'b0)
               $display("FAIL led3_rise got led3=%b nv=%b want 1 0", led3, next_valid);
            else pass_cnt++;
         end
         if (i == 9) begin
            tot_cnt++;
            if (next_valid !== 1'b1 || next_floor !== 2'd3)
               $display("FAIL target3 got nv=%b nf=%0d want 1 3", next_valid, next_floor);
            else pass_cnt++;
         end
      end
      btn[3] = 1'b1;
      for (int i = 0; i < N + 6; i++) begin
         tick();
         if (dut.r_pe[3]) pe_cnt++;
      end
      tot_cnt++;
      if (pe_cnt !== 1) $display("FAIL single_event got %0d want 1", pe_cnt);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      press(2, 3);
      tot_cnt++;
      if (led2 !== 1'b0 || dut.r_cnt[2] !== 8'd0)
         $display("FAIL glitch3 got led2=%b cnt=%0d want 0 0", led2, dut.r_cnt[2]);
      else pass_cnt++;
      press(2, 4);
      tot_cnt++;
      if (led2 !== 1'b1) $display("FAIL glitch4 got led2=%b want 1", led2);
      else pass_cnt++;
   endtask

   task automatic test_service_clear();
      // pend = 110 here; clear floor 2, then add floor 1
      current_floor = 2'd2; door_open = 1'b1;
      tick();
      door_open = 1'b0; current_floor = 2'd1;
      press(1, 6);
      tot_cnt++;
      if ({led3, led2, led1} !== 3'b101 || next_floor !== 2'd1)
         $display("FAIL pend101 got leds=%b nf=%0d want 101 1", {led3, led2, led1}, next_floor);
      else pass_cnt++;
      door_open = 1'b1;
      tick();
      tot_cnt++;
      if (led1 !== 1'b0 || led3 !== 1'b1 || next_floor !== 2'd1)
         $display("FAIL door_clear got l1=%b l3=%b nf=%0d want 0 1 1", led1, led3, next_floor);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (next_floor !== 2'd3) $display("FAIL door_next got %0d want 3", next_floor);
      else pass_cnt++;
      press(1, 10);
      door_open = 1'b0;
      tick();
      tot_cnt++;
      if (led1 !== 1'b0) $display("FAIL press_at_open_door got led1=%b want 0", led1);
      else pass_cnt++;
   endtask

   task automatic test_tie();
      current_floor = 2'd1;
      press(1, 6);
      current_floor = 2'd2;
      repeat (2) tick();
      tot_cnt++;
      if (next_floor !== 2'd3) $display("FAIL tie_up got %0d want 3", next_floor);
      else pass_cnt++;
      current_floor = 2'd3; tick();
      current_floor = 2'd2; repeat (2) tick();
      tot_cnt++;
      if (next_floor !== 2'd1) $display("FAIL tie_down got %0d want 1", next_floor);
      else pass_cnt++;
   endtask

   task automatic test_sos();
      press(2, 6);
      tot_cnt++;
      if ({led3, led2, led1} !== 3'b111) $display("FAIL sos_pre got %b want 111", {led3, led2, led1});
      else pass_cnt++;
      sos_mode = 1'b1;
      tick();
      tot_cnt++;
      if ({led3, led2, led1} !== 3'b000) $display("FAIL sos_clear got %b want 000", {led3, led2, led1});
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (next_valid !== 1'b0 || next_floor !== 2'd0)
         $display("FAIL sos_next got nv=%b nf=%0d want 0 0", next_valid, next_floor);
      else pass_cnt++;
      press(3, 6);
      tot_cnt++;
      if (led3 !== 1'b0) $display("FAIL sos_press got led3=%b want 0", led3);
      else pass_cnt++;
      sos_mode = 1'b0;
      press(3, 6);
      tot_cnt++;
      if ({led3, led2, led1} !== 3'b100) $display("FAIL sos_resume got %b want 100", {led3, led2, led1});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int rise = -1;
      press(2, 6);
      btn[1] = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      tot_cnt++;
      if ({led3, led2, led1, next_valid, next_floor} !== 6'b0)
         $display("FAIL reset_mid got %b want 000000", {led3, led2, led1, next_valid, next_floor});
      else pass_cnt++;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (led1 === 1'b1 && rise < 0) rise = i;
      end
      tot_cnt++;
      if (rise !== N + 4) $display("FAIL reset_release_latency got %0d want %0d", rise, N + 4);
      else pass_cnt++;
      tot_cnt++;
      if ({led3, led2, led1} !== 3'b001 || next_floor !== 2'd1)
         $display("FAIL reset_release_state got leds=%b nf=%0d want 001 1", {led3, led2, led1}, next_floor);
      else pass_cnt++;
      btn[1] = 1'b1;
      repeat (N + 6) tick();
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_service_clear();
      test_tie();
      test_sos();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/call_request_unit.md
# call_request_unit

Upstream stage of the elevator controller in `TOP`. It takes the three raw active-low floor call buttons, synchronizes and debounces them, and latches each press as a pending call. It drives the call LEDs and presents one registered "next target floor", chosen by distance and travel direction, to the controller FSM. A call is cleared when the controller reports the door open at that floor, and all calls are cleared in SOS mode.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a level change is accepted. Legal range 1..255.

Ports (direction, width, meaning):
- `clk_50` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `button1_pushed`, `button2_pushed`, `button3_pushed` in 1 each: raw asynchronous floor call buttons; 0 = pressed, 1 = released.
- `current_floor` in 2: floor reported by the controller; 1..3 are valid, 0 means unknown.
- `door_open` in 1: door open at `current_floor`.
- `sos_mode` in 1: emergency mode active.
- `led1`, `led2`, `led3` out 1 each: pending call for floors 1, 2, 3.
- `next_valid` out 1: at least one call is pending.
- `next_floor` out 2: target floor 1..3; 0 when `next_valid`=0.

## Operation

- Per button, a 2-FF synchronizer: `s1` <= raw, then `s2` <= `s1`.
- Per button, a debouncer with an accepted level `acc` and an 8-bit counter `cnt`:
  - If `s2` == `acc`: `cnt` <= 0.
  - Otherwise: `cnt` increments. On the edge where `cnt` would reach `DEBOUNCE_CYCLES`, `acc` <= `s2` and `cnt` <= 0.
- Press event `pe[k]` = `acc[k]` transitioned 1→0 on the previous edge. It is a one-cycle registered pulse. Releases generate no event.
- Pending register `pend[3:1]`, evaluated in this order each edge:
  - If `sos_mode`=1: `pend` <= 0 and events are discarded.
  - Else, if `door_open`=1 and `current_floor`=k: `pend[k]` <= 0. This wins over a simultaneous `pe[k]`; a call at the floor being serviced is never latched.
  - Else, if `pe[k]`=1: `pend[k]` <= 1.
  - Otherwise `pend[k]` holds.
  - Set and clear on different floors in the same cycle both take effect.
- Direction tracker `dir_up`: keeps the last valid `current_floor`. A valid new value greater than the last sets `dir_up`=1; a smaller one sets `dir_up`=0. Transitions to or from 0 are ignored.
- Target selection (combinational on `pend`, `current_floor`, `dir_up`; registered into `next_floor`/`next_valid`):
  - No pending calls: `next_valid`=0, `next_floor`=0.
  - `current_floor`=0: lowest pending floor.
  - Otherwise: the pending floor with minimum distance |k − `current_floor`|. A distance of 0 is allowed, so the current floor is chosen if it is pending.
  - Tie (current floor 2 with calls at 1 and 3): floor 3 if `dir_up`=1, else floor 1.
- `ledk` = `pend[k]`, direct register outputs.

## Timing

- Reset values: `s1`=`s2`=`acc`=1, `cnt`=0, `pe`=0, `pend`=0, `dir_up`=1, last floor = 0. Outputs: `led1..3`=0, `next_valid`=0, `next_floor`=0.
- Reset is honoured on any edge, including mid-debounce or mid-service. Everything returns to reset values; no event is generated by the reset itself.
- Press latency, for a raw low held continuously:
  - Edge E0 first captures 0 into `s1`.
  - `acc` falls at edge E(1+N), where N = `DEBOUNCE_CYCLES`.
  - `pe` is high after E(2+N).
  - `ledk` rises at E(3+N).
  - `next_floor`/`next_valid` reflect the change at E(4+N).
  - With N=4: LED after 7 edges, target after 8 edges.
- Pulse-length rules: a low pulse seen by `s2` for fewer than N consecutive cycles is ignored. A bounce back to 1 restarts the count.
- A held button produces exactly one event. Re-arming requires an accepted release (N stable high cycles).
- Clearing by `door_open`/`sos_mode`: `ledk` falls at the next edge, and `next_*` follows one edge later.
- `next_floor` always lags `pend` by exactly one cycle; the controller must tolerate a one-cycle stale target.

## Test plan

- Reset, then hold `button3_pushed`=0 for 12 cycles with N=4 and `current_floor`=1: `led3` rises exactly 7 edges after the first low sample; `next_valid`=1 and `next_floor`=3 one edge later; only one event occurs.
- Glitch: `button2_pushed` low for 3 cycles, then high: `led2` stays 0 and `cnt` returns to 0. Repeat with 4 cycles: `led2`=1.
- Service clear: `pend`=3'b101, `current_floor`=1, `door_open`=1: `led1` falls next edge, `led3` stays 1, `next_floor` moves 1→3. A press of button 1 while the door is open at floor 1 is not latched.
- Tie: `current_floor` goes 1→2 (so `dir_up`=1) with calls at 1 and 3: `next_floor`=3. Then `current_floor` goes 3→2 with both pending: `next_floor`=1.
- SOS: calls at 1, 2, 3 are pending, then `sos_mode`=1: all LEDs go 0 next edge; presses during SOS are never latched; normal latching resumes after `sos_mode`=0.
- Reset mid-operation: assert `reset` while button 1 is mid-debounce with `pend`=3'b110: all outputs are 0 after the edge, and holding button 1 through reset release yields one event N+3 edges after release.
